// File: rtl/uart_crypto_bridge_pkg.sv
// ---------------------------------------------------------------------------
// uart_crypto_bridge_pkg
// Shared definitions for the UART-to-cipher bridge: the controller state
// enumeration and the single-byte command/response codes of the serial
// protocol.
// ---------------------------------------------------------------------------
package uart_crypto_bridge_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RX_KEY  = 3'd1,
      S_RX_DATA = 3'd2,
      S_RUN     = 3'd3,
      S_TX      = 3'd4,
      S_REPLY   = 3'd5
   } state_e;

   localparam logic [7:0] CMD_KEY = 8'h4B;  // 'K' load key
   localparam logic [7:0] CMD_ENC = 8'h45;  // 'E' encrypt payload
   localparam logic [7:0] CMD_DEC = 8'h44;  // 'D' decrypt payload
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

endpackage

// File: rtl/uart_crypto_bridge_heartbeat.sv
// ---------------------------------------------------------------------------
// heartbeat_counter
// Free-running divider that toggles led_o once every HEARTBEAT_CYCLES clocks.
// The counter runs 0..HEARTBEAT_CYCLES-1 and the LED flips on the wrap.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (counter and LED to 0)
//   led_o   heartbeat output
// ---------------------------------------------------------------------------
module heartbeat_counter #(
   parameter int HEARTBEAT_CYCLES = 6000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic led_o
);

   localparam int CW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(HEARTBEAT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          led_q, led_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      led_d = led_q;
      if (cnt_q == LAST) begin
         cnt_d = '0;
         led_d = ~led_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         led_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/uart_crypto_bridge.sv
// ---------------------------------------------------------------------------
// uart_crypto_bridge
// Byte-oriented command front end for a block cipher core. A command byte
// ('K' key, 'E' encrypt, 'D' decrypt) is followed by BLOCK_BYTES payload
// bytes. Keys are acknowledged with ACK; payloads are sent to the core and
// the result is streamed back MSB byte first. Bad commands, or data with no
// key loaded, get a NAK.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   rx_ready, rx_data     received-byte strobe and byte
//   tx_ready              transmitter idle
//   tx_data, tx_enable    byte to send, one-cycle send request
//   core_start            one-cycle start pulse to the cipher core
//   core_decrypt          direction, held from start until done
//   core_key, core_din    stored key and payload (first byte in MSBs)
//   core_done, core_dout  result strobe and result block
//   LED                   {0000, running, err, key_valid, heartbeat}
//   dbg_state             current controller state, for observation
// Transmit handshake: tx_enable is raised only in a cycle where tx_ready is
// high, tx_data is valid in that same cycle, and the cycle following each
// pulse never carries another pulse so the UART can drop tx_ready.
// ---------------------------------------------------------------------------
module uart_crypto_bridge
   import uart_crypto_bridge_pkg::*;
#(
   parameter int BLOCK_BYTES      = 16,
   parameter int HEARTBEAT_CYCLES = 6000000,
   parameter int TIMEOUT_CYCLES   = 1000000
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     rx_ready,
   input  logic [7:0]               rx_data,
   input  logic                     tx_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_enable,
   output logic                     core_start,
   output logic                     core_decrypt,
   output logic [8*BLOCK_BYTES-1:0] core_key,
   output logic [8*BLOCK_BYTES-1:0] core_din,
   input  logic                     core_done,
   input  logic [8*BLOCK_BYTES-1:0] core_dout,
   output logic [7:0]               LED,
   output state_e                   dbg_state
);

   localparam int BW = 8 * BLOCK_BYTES;
   localparam int CW = $clog2(BLOCK_BYTES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tout_q, tout_d;
   logic [BW-1:0] rx_sh_q, rx_sh_d;
   logic [BW-1:0] key_q, key_d;
   logic [BW-1:0] din_q, din_d;
   logic [BW-1:0] tx_sh_q, tx_sh_d;
   logic          key_valid_q, key_valid_d;
   logic          err_q, err_d;
   logic          dec_q, dec_d;
   logic          gap_q, gap_d;
   logic          start_q, start_d;
   logic          hb_led;
   logic [BW-1:0] rx_next;

   // Single-byte responses sit in the top byte of the transmit shift register.
   function automatic logic [BW-1:0] reply_word(input logic [7:0] b);
      return BW'(b) << (BW - 8);
   endfunction

   // Incoming byte enters at the LSB end so the first byte ends up in the MSBs.
   assign rx_next = BW'({rx_sh_q, rx_data});

   assign tx_data   = tx_sh_q[BW-1 -: 8];
   assign tx_enable = ((state_q == S_TX) || (state_q == S_REPLY)) && tx_ready && !gap_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tout_d      = tout_q;
      rx_sh_d     = rx_sh_q;
      key_d       = key_q;
      din_d       = din_q;
      tx_sh_d     = tx_sh_q;
      key_valid_d = key_valid_q;
      err_d       = err_q;
      dec_d       = dec_q;
      gap_d       = tx_enable;
      start_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d  = '0;
            tout_d = '0;
            if (rx_ready) begin
               unique case (rx_data)
                  CMD_KEY: state_d = S_RX_KEY;
                  CMD_ENC: begin
                     state_d = S_RX_DATA;
                     dec_d   = 1'b0;
                  end
                  CMD_DEC: begin
                     state_d = S_RX_DATA;
                     dec_d   = 1'b1;
                  end
                  default: begin
                     tx_sh_d = reply_word(RSP_NAK);
                     state_d = S_REPLY;
                  end
               endcase
            end
         end

         S_RX_KEY, S_RX_DATA: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (rx_ready) begin
               rx_sh_d = rx_next;
               tout_d  = '0;
               if (cnt_q == LAST_BYTE) begin
                  cnt_d = '0;
                  if (state_q == S_RX_KEY) begin
                     // Key register only changes here, on a complete block.
                     key_d       = rx_next;
                     key_valid_d = 1'b1;
                     tx_sh_d     = reply_word(RSP_ACK);
                     state_d     = S_REPLY;
                  end else begin
                     din_d = rx_next;
                     if (key_valid_q) begin
                        start_d = 1'b1;
                        state_d = S_RUN;
                     end else begin
                        tx_sh_d = reply_word(RSP_NAK);
                        state_d = S_REPLY;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (tout_q == TOUT_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               tout_d  = '0;
               rx_sh_d = '0;
               state_d = S_IDLE;
            end else begin
               tout_d = tout_q + 1'b1;
            end
         end

         S_RUN: begin
            if (rx_ready) err_d = 1'b1;
            if (core_done) begin
               tx_sh_d = core_dout;
               cnt_d   = '0;
               state_d = S_TX;
            end
         end

         S_TX: begin
            if (rx_ready) err_d = 1'b1;
            if (tx_enable) begin
               tx_sh_d = BW'({tx_sh_q, 8'h00});
               if (cnt_q == LAST_BYTE) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         S_REPLY: begin
            if (rx_ready) err_d = 1'b1;
            if (tx_enable) begin
               tx_sh_d = '0;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         tout_q      <= '0;
         rx_sh_q     <= '0;
         key_q       <= '0;
         din_q       <= '0;
         tx_sh_q     <= '0;
         key_valid_q <= 1'b0;
         err_q       <= 1'b0;
         dec_q       <= 1'b0;
         gap_q       <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tout_q      <= tout_d;
         rx_sh_q     <= rx_sh_d;
         key_q       <= key_d;
         din_q       <= din_d;
         tx_sh_q     <= tx_sh_d;
         key_valid_q <= key_valid_d;
         err_q       <= err_d;
         dec_q       <= dec_d;
         gap_q       <= gap_d;
         start_q     <= start_d;
      end
   end

   heartbeat_counter #(
      .HEARTBEAT_CYCLES(HEARTBEAT_CYCLES)
   ) u_heartbeat (
      .clk_i (CLK),
      .rst_ni(RST_N),
      .led_o (hb_led)
   );

   assign core_start   = start_q;
   assign core_decrypt = dec_q;
   assign core_key     = key_q;
   assign core_din     = din_q;
   assign dbg_state    = state_q;
   assign LED          = {4'b0000, (state_q == S_RUN), err_q, key_valid_q, hb_led};

endmodule

// File: tb/tb_uart_crypto_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_crypto_bridge
// Scoreboard bench: each command pushes the bytes the bridge should transmit
// and the core_start it should issue; monitors pop and compare on every
// tx_enable / core_start. A small cipher-core model answers core_start.
// ---------------------------------------------------------------------------
module tb_uart_crypto_bridge;
   import uart_crypto_bridge_pkg::*;

   localparam int BB = 16;
   localparam int BW = 8 * BB;
   localparam int HB = 50;
   localparam int TO = 40;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b1;
   logic          rx_ready = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          tx_ready = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_enable;
   logic          core_start;
   logic          core_decrypt;
   logic [BW-1:0] core_key;
   logic [BW-1:0] core_din;
   logic          core_done = 1'b0;
   logic [BW-1:0] core_dout = '0;
   logic [7:0]    LED;
   state_e        dbg_state;

   uart_crypto_bridge #(
      .BLOCK_BYTES(BB), .HEARTBEAT_CYCLES(HB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .rx_ready(rx_ready), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_data(tx_data), .tx_enable(tx_enable),
      .core_start(core_start), .core_decrypt(core_decrypt),
      .core_key(core_key), .core_din(core_din), .core_done(core_done),
      .core_dout(core_dout), .LED(LED), .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [BW-1:0] key;
      logic [BW-1:0] din;
      logic          dec;
   } start_t;

   int            n_vec = 0;
   int            n_bad = 0;
   logic [7:0]    exp_q[$];
   start_t        exp_st_q[$];
   start_t        mon_e;
   logic [BW-1:0] m_key;
   logic          m_key_valid;
   logic          m_err;
   logic          core_fixed = 1'b0;
   logic          core_busy = 1'b0;
   logic          prev_en = 1'b0;
   logic [BW-1:0] core_res;
   int            tx_seen = 0;

   // Reference cipher: fixed pattern mode, or key ^ data ^ direction mask.
   function automatic logic [BW-1:0] core_fn(input logic [BW-1:0] k, input logic [BW-1:0] d,
                                             input logic dec, input logic fixed);
      if (fixed) return {BB{8'hA5}};
      return k ^ d ^ {BB{(dec ? 8'h5A : 8'hC3)}};
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: event seen, none expected", name);
   endtask

   // ---------------- clock-independent stimulus helpers --------------------
   initial begin
      forever begin
         @(posedge CLK);
         #1 tx_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) @(posedge CLK);
      #1;
      rx_ready = 1'b1;
      rx_data  = b;
      @(posedge CLK);
      #1;
      rx_ready = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic do_key(input logic [BW-1:0] blk, input int gap);
      exp_q.push_back(RSP_ACK);
      send_byte(CMD_KEY, gap);
      for (int i = 0; i < BB; i++) send_byte(blk[BW-1-8*i -: 8], gap);
      m_key       = blk;
      m_key_valid = 1'b1;
   endtask

   task automatic do_crypt(input logic dec, input logic [BW-1:0] blk);
      logic [BW-1:0] res;
      if (m_key_valid) begin
         exp_st_q.push_back({m_key, blk, dec});
         res = core_fn(m_key, blk, dec, core_fixed);
         for (int i = 0; i < BB; i++) exp_q.push_back(res[BW-1-8*i -: 8]);
      end else begin
         exp_q.push_back(RSP_NAK);
      end
      send_byte(dec ? CMD_DEC : CMD_ENC, -1);
      for (int i = 0; i < BB; i++) send_byte(blk[BW-1-8*i -: 8], -1);
   endtask

   task automatic do_bad(input logic [7:0] b);
      exp_q.push_back(RSP_NAK);
      send_byte(b, -1);
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge CLK);
         if (exp_q.size() == 0 && exp_st_q.size() == 0 && !core_busy && dbg_state == S_IDLE) break;
      end
      if (k == 3000) flag({name, "_drain_timeout"});
      repeat (3) @(negedge CLK);
      check({name, "_led_status"}, BW'(LED[2:1]), BW'({m_err, m_key_valid}));
      check({name, "_core_key"}, core_key, m_key);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_tx_enable"}, BW'(tx_enable), '0);
      check({name, "_tx_data"}, BW'(tx_data), '0);
      check({name, "_core_start"}, BW'(core_start), '0);
      check({name, "_core_decrypt"}, BW'(core_decrypt), '0);
      check({name, "_led"}, BW'(LED), '0);
      check({name, "_core_key"}, core_key, '0);
      check({name, "_core_din"}, core_din, '0);
      check({name, "_state"}, BW'(dbg_state), BW'(S_IDLE));
   endtask

   // Release reset just after a falling edge and verify the heartbeat phase:
   // after n rising edges LED[0] must equal (n / HB) mod 2.
   task automatic release_and_check_hb();
      @(negedge CLK);
      #1 RST_N = 1'b1;
      for (int n = 1; n <= 2 * HB; n++) begin
         @(negedge CLK);
         if (n == HB - 1 || n == HB || n == 2 * HB - 1 || n == 2 * HB)
            check($sformatf("heartbeat_n%0d", n), BW'(LED[0]), BW'((n / HB) % 2));
      end
   endtask

   // ---------------- monitors and core model -------------------------------
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            prev_en = 1'b0;
         end else begin
            if (tx_enable) begin
               check("tx_handshake", BW'({tx_ready, prev_en}), BW'(2'b10));
               if (exp_q.size() == 0) flag("tx_unexpected");
               else check("tx_byte", BW'(tx_data), BW'(exp_q.pop_front()));
               tx_seen++;
            end
            prev_en = tx_enable;
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (RST_N && core_start) begin
            if (exp_st_q.size() == 0) begin
               flag("core_start_unexpected");
            end else begin
               mon_e = exp_st_q.pop_front();
               check("start_key", core_key, mon_e.key);
               check("start_din", core_din, mon_e.din);
               check("start_dec", BW'(core_decrypt), BW'(mon_e.dec));
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (RST_N && core_start) begin
            core_busy = 1'b1;
            core_res  = core_fn(core_key, core_din, core_decrypt, core_fixed);
            repeat ($urandom_range(1, 6)) @(negedge CLK);
            core_done = 1'b1;
            core_dout = core_res;
            @(negedge CLK);
            core_done = 1'b0;
            core_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence -----------------------------------------
   initial begin
      logic [BW-1:0] blk;
      logic [BW-1:0] key_seq;
      logic [7:0]    b;
      int            base;

      m_key = '0; m_key_valid = 1'b0; m_err = 1'b0;
      #1 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      release_and_check_hb();

      // Unknown command gets a NAK and the FSM returns to IDLE, no error.
      do_bad(8'h7A);
      wait_idle("bad_cmd");
      check("bad_cmd_state", BW'(dbg_state), BW'(S_IDLE));

      // Data before any key: NAK and no core_start.
      do_crypt(1'b0, {BB{8'h33}});
      wait_idle("no_key");

      // Key 00..0F.
      for (int i = 0; i < BB; i++) key_seq[BW-1-8*i -: 8] = 8'(i);
      do_key(key_seq, -1);
      wait_idle("key_load");
      check("key_load_value", core_key, key_seq);
      check("key_load_led1", BW'(LED[1]), BW'(1));

      // Encrypt 16 x 0x11 with the core returning all 0xA5.
      core_fixed = 1'b1;
      do_crypt(1'b0, {BB{8'h11}});
      wait_idle("enc_fixed");
      core_fixed = 1'b0;

      // Randomized mix of key loads, encrypts, decrypts and bad commands.
      for (int it = 0; it < 24; it++) begin
         for (int i = 0; i < BB / 4; i++) blk[32*i +: 32] = $urandom;
         case ($urandom_range(0, 3))
            0: do_key(blk, -1);
            1: do_crypt(1'b0, blk);
            2: do_crypt(1'b1, blk);
            default: begin
               do b = 8'($urandom); while (b == CMD_KEY || b == CMD_ENC || b == CMD_DEC);
               do_bad(b);
            end
         endcase
         wait_idle($sformatf("rand%0d", it));
      end

      // Bytes spaced exactly TO cycles apart land on the expiry cycle and count.
      for (int i = 0; i < BB / 4; i++) blk[32*i +: 32] = $urandom;
      do_key(blk, TO - 1);
      wait_idle("timeout_edge");

      // Partial key then silence: timeout after exactly TO idle cycles.
      send_byte(CMD_KEY, 1);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), -1);
      repeat (TO) @(negedge CLK);
      check("timeout_not_early", BW'(dbg_state), BW'(S_RX_KEY));
      @(negedge CLK);
      check("timeout_state", BW'(dbg_state), BW'(S_IDLE));
      m_err = 1'b1;
      check("timeout_led2", BW'(LED[2]), BW'(1));
      wait_idle("timeout");

      // Reset while the third result byte is pending.
      for (int i = 0; i < BB / 4; i++) blk[32*i +: 32] = $urandom;
      base = tx_seen;
      do_crypt(1'b0, blk);
      for (int k = 0; k < 3000 && tx_seen < base + 2; k++) @(negedge CLK);
      check("pre_reset_tx_count", BW'(tx_seen - base), BW'(2));
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      exp_q.delete();
      exp_st_q.delete();
      m_key = '0; m_key_valid = 1'b0; m_err = 1'b0;
      check_reset_outputs("midtx_reset");
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("reset_hold_tx_enable", BW'(tx_enable), '0);
      end
      release_and_check_hb();
      for (int i = 0; i < BB / 4; i++) blk[32*i +: 32] = $urandom;
      do_key(blk, -1);
      wait_idle("post_reset_key");

      // A byte arriving while the NAK is pending is dropped and sets err.
      do_bad(8'h7A);
      send_byte(8'($urandom), 0);
      m_err = 1'b1;
      wait_idle("stray_byte");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_crypto_bridge.md
UART_CRYPTO_BRIDGE -- requirements
Module: uart_crypto_bridge

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 16: payload/key length in bytes; legal range 1..32.
REQ-002 SHALL have parameter HEARTBEAT_CYCLES, default 6000000: CLK cycles per LED[0] toggle.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle CLK cycles between payload bytes.
REQ-004 Port CLK, input, 1: single clock.
REQ-005 Port RST_N, input, 1: reset, asynchronous, active-low.
REQ-006 Port rx_ready, input, 1: one-cycle strobe, rx_data valid.
REQ-007 Port rx_data, input, 8: byte received from UART.
REQ-008 Port tx_ready, input, 1: UART transmitter idle.
REQ-009 Port tx_data, output, 8: byte to transmit.
REQ-010 Port tx_enable, output, 1: one-cycle transmit request.
REQ-011 Port core_start, output, 1: one-cycle start pulse to cipher core.
REQ-012 Port core_decrypt, output, 1: 0 encrypt, 1 decrypt; stable from core_start to core_done.
REQ-013 Port core_key, output, 8*BLOCK_BYTES: stored key.
REQ-014 Port core_din, output, 8*BLOCK_BYTES: stored payload, first-received byte in MSBs.
REQ-015 Port core_done, input, 1: one-cycle strobe, core_dout valid.
REQ-016 Port core_dout, input, 8*BLOCK_BYTES: cipher result.
REQ-017 Port LED, output, 8: status.

Function
REQ-018 FSM states SHALL be IDLE, RX_KEY, RX_DATA, RUN, TX, REPLY.
REQ-019 IDLE, rx_ready with rx_data 0x4B ('K') -> RX_KEY; 0x45 ('E') -> RX_DATA, decrypt=0; 0x44 ('D') -> RX_DATA, decrypt=1; any other byte -> REPLY with 0x15 (NAK).
REQ-020 RX_KEY/RX_DATA SHALL shift in exactly BLOCK_BYTES bytes using a byte counter that wraps to 0 on completion.
REQ-021 After the last key byte, the FSM SHALL set key_valid and go to REPLY with 0x06 (ACK).
REQ-022 After the last data byte: if key_valid=1, pulse core_start in the next cycle and enter RUN; otherwise go to REPLY with 0x15.
REQ-023 RUN SHALL wait for core_done, capture core_dout into the output shift register on that cycle, then enter TX.
REQ-024 TX SHALL send BLOCK_BYTES bytes, MSB byte first, then return to IDLE.
REQ-025 REPLY SHALL send exactly one byte, then return to IDLE.
REQ-026 Transmit handshake: tx_enable SHALL pulse one cycle only while tx_ready=1, with tx_data valid in that cycle.
REQ-027 After each tx_enable pulse, the bridge SHALL ignore tx_ready for one cycle before issuing the next byte.
REQ-028 rx_ready strobes arriving in RUN, TX or REPLY SHALL be dropped and SHALL set err.
REQ-029 In RX_KEY/RX_DATA, TIMEOUT_CYCLES cycles without rx_ready SHALL discard the partial block, set err, leave key unchanged, and return to IDLE with no reply.
REQ-030 A partial key load SHALL never modify core_key; the key register SHALL update atomically on completion.
REQ-031 An rx_ready coincident with timeout expiry SHALL be treated as a received byte; the timeout SHALL not fire in that cycle.
REQ-032 LED[0] SHALL toggle every HEARTBEAT_CYCLES cycles, counter range 0..HEARTBEAT_CYCLES-1.
REQ-033 LED[1] SHALL equal key_valid, LED[2] SHALL equal sticky err, LED[3] SHALL be 1 in RUN, LED[7:4] SHALL be 0.
REQ-034 A 'K' command received while key_valid=1 SHALL overwrite the key; err SHALL clear only on reset.

Reset
REQ-035 RST_N low SHALL force, asynchronously: state IDLE; tx_enable, core_start, core_decrypt and LED all 0; tx_data 0x00; core_key and core_din 0; key_valid, err and all counters 0.
REQ-036 Reset asserted mid-operation SHALL abort the operation with no further tx_enable or core_start pulse; core_done pulses arriving after reset SHALL be ignored.

Structure
REQ-037 A shared package SHALL hold the state enumeration and the command/response constants CMD_KEY=0x4B, CMD_ENC=0x45, CMD_DEC=0x44, RSP_ACK=0x06, RSP_NAK=0x15.
REQ-038 The heartbeat SHALL be a separate sub-module, heartbeat_counter, parameterised by HEARTBEAT_CYCLES.

Verification
REQ-039 Send 'K' followed by 16 bytes 0x00..0x0F -> one TX byte 0x06; core_key=0x000102...0F; LED[1]=1.
REQ-040 With key loaded, send 'E' followed by 16 bytes 0x11; model returns core_dout=0xA5...A5 -> one core_start with core_decrypt=0; 16 TX bytes 0xA5.
REQ-041 After reset, send 'E' followed by 16 bytes -> TX 0x15; no core_start.
REQ-042 Send 0x7A -> TX 0x15; state returns to IDLE.
REQ-043 Send 'K' followed by 5 bytes, then TIMEOUT_CYCLES idle cycles -> err=1, LED[2]=1, previous key unchanged, no TX.
REQ-044 Drop RST_N during TX of byte 3 -> all outputs 0 immediately; no further tx_enable pulse; a subsequent 'K' sequence completes normally.
